// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions, AXI responses and TX state encoding
package uart_pkg;
  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_LEVEL = 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy level
// Ports: push/din write side, pop/dout read side (dout shows the head entry), full/empty/level status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full  = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/axil_uart_tx.sv
// axil_uart_tx: AXI4-Lite slave buffering bytes in a FIFO and sending them as 8N1 UART frames on txd
// Ports: AXI4-Lite write (aw/w/b) and read (ar/r) channels; txd serial output, idle high.
// Registers: TXDATA at +0x0 (write pushes wdata[7:0]), STATUS at +0x4 (full, empty, busy, level[15:8]).
module axil_uart_tx
  import uart_pkg::*;
#(
  parameter int              ADDR_WIDTH   = 32,
  parameter int              DATA_WIDTH   = 32,
  parameter logic [31:0]     BASE_ADDR    = 32'h0000_0100,
  parameter int              CLKS_PER_BIT = 868,
  parameter int              FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    txd
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic [LW-1:0] fifo_level;
  logic aw_fire, ar_fire, aw_hit, ar_hit, aw_tx, ar_stat, baud_done;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, txd_q, txd_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, status;
  uart_tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic unused;
  assign unused = &{1'b0, awaddr[1:0], araddr[1:0], wdata[DATA_WIDTH-1:8], wstrb[DATA_WIDTH/8-1:1]};
  // Ready is combinational so a write or read is accepted in the same cycle its valids meet.
  assign aw_fire   = !rst && awvalid && wvalid && !bvalid_q;
  assign ar_fire   = !rst && arvalid && !rvalid_q;
  assign awready   = aw_fire;
  assign wready    = aw_fire;
  assign arready   = ar_fire;
  assign aw_hit    = awaddr[ADDR_WIDTH-1:3] == BASE[ADDR_WIDTH-1:3];
  assign ar_hit    = araddr[ADDR_WIDTH-1:3] == BASE[ADDR_WIDTH-1:3];
  assign aw_tx     = {awaddr[2], 2'b00} == TXDATA_OFS;
  assign ar_stat   = {araddr[2], 2'b00} == STATUS_OFS;
  assign fifo_push = aw_fire && aw_hit && aw_tx && wstrb[0] && !fifo_full;
  assign baud_done = baud_q == BW'(CLKS_PER_BIT - 1);
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign txd       = txd_q;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(fifo_push), .din(wdata[7:0]), .pop(fifo_pop),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
  );
  always_comb begin
    status                  = '0;
    status[STAT_FULL]       = fifo_full;
    status[STAT_EMPTY]      = fifo_empty;
    status[STAT_BUSY]       = state_q != ST_IDLE;
    status[STAT_LEVEL +: LW] = fifo_level;
    bvalid_d = aw_fire || (bvalid_q && !bready);
    bresp_d  = !aw_fire ? bresp_q : !aw_hit ? RESP_DECERR :
               (aw_tx && wstrb[0] && fifo_full) ? RESP_SLVERR : RESP_OKAY;
    rvalid_d = ar_fire || (rvalid_q && !rready);
    rresp_d  = !ar_fire ? rresp_q : ar_hit ? RESP_OKAY : RESP_DECERR;
    rdata_d  = !ar_fire ? rdata_q : (ar_hit && ar_stat) ? status : '0;
  end
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
    baud_d   = baud_done ? '0 : baud_q + BW'(1);
    if (state_q == ST_IDLE) begin
      baud_d   = '0;
      bit_d    = '0;
      fifo_pop = !fifo_empty;
      shift_d  = fifo_empty ? shift_q : fifo_dout;
      state_d  = fifo_empty ? ST_IDLE : ST_START;
    end else if (baud_done) begin
      if (state_q == ST_START) state_d = ST_DATA;
      if (state_q == ST_STOP) state_d = ST_IDLE;
      if (state_q == ST_DATA) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? ST_STOP : ST_DATA;
      end
    end
    // txd is registered from the current state, so the line lags the FSM by one cycle.
    txd_d = state_q == ST_START ? 1'b0 : state_q == ST_DATA ? shift_q[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end
endmodule

// File: tb/tb_axil_uart_tx.sv
// tb_axil_uart_tx: randomized self-checking bench decoding txd against a queue of written bytes
module tb_axil_uart_tx;
  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;
  localparam time BIT = CPB * 10;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  logic clk = 0, rst = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, txd;
  logic [1:0] bresp, rresp;
  int n_cmp = 0, n_fail = 0, rst_cnt = 0, n_falls = 0;
  logic [7:0] rx_b[$];
  bit rx_f[$];
  time fall_t[$];
  time m_t;
  int m_rc;
  bit m_ok;
  logic [7:0] m_b;

  axil_uart_tx #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

  // Independent UART receiver: samples mid-bit, discards frames interrupted by reset.
  always begin
    @(negedge txd);
    n_falls++;
    m_t = $time;
    m_rc = rst_cnt;
    m_ok = 1;
    #(BIT / 2 + 2);
    if (txd !== 1'b0) m_ok = 0;
    for (int i = 0; i < 8; i++) begin
      #(BIT);
      m_b[i] = txd;
    end
    #(BIT);
    if (txd !== 1'b1) m_ok = 0;
    if (m_rc == rst_cnt) begin
      rx_b.push_back(m_b);
      rx_f.push_back(m_ok);
      fall_t.push_back(m_t);
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] status_word(bit f, bit e, bit b, int lvl);
    return 32'(f) | (32'(e) << 1) | (32'(b) << 2) | (32'(lvl) << 8);
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output time t, output bit ok);
    ok = 0; r = 2'bxx; t = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    #1;
    for (int n = 0; n < 400 && !(awready && wready); n++) begin
      @(negedge clk);
      #1;
    end
    if (awready && wready) begin
      @(posedge clk);
      t = $time;
      #1;
      awvalid = 0; wvalid = 0;
      for (int n = 0; n < 400 && !bvalid; n++) @(negedge clk);
      if (bvalid) begin
        r = bresp; ok = 1; bready = 1;
        @(posedge clk);
        #1;
        bready = 0;
      end
    end else begin
      awvalid = 0; wvalid = 0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output bit ok);
    ok = 0; d = 'x; r = 2'bxx;
    @(negedge clk);
    araddr = a; arvalid = 1;
    #1;
    for (int n = 0; n < 400 && !arready; n++) begin
      @(negedge clk);
      #1;
    end
    if (arready) begin
      @(posedge clk);
      #1;
      arvalid = 0;
      for (int n = 0; n < 400 && !rvalid; n++) @(negedge clk);
      if (rvalid) begin
        d = rdata; r = rresp; ok = 1; rready = 1;
        @(posedge clk);
        #1;
        rready = 0;
      end
    end else arvalid = 0;
  endtask

  task automatic wait_rx(input int k, input int budget);
    for (int n = 0; n < budget && rx_b.size() < k; n++) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_cmp++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin n_fail++;
      $display("FAIL reset_handshake: got %b expected 00000", {awready, wready, arready, bvalid, rvalid}); end
    n_cmp++; if ({bresp, rresp, rdata} !== 36'h0) begin n_fail++;
      $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h expected zeros", bresp, rresp, rdata); end
    rst = 0;
    axi_read(BASE + 4, d, r, ok);
    n_cmp++; if (!ok || d !== status_word(0, 1, 0, 0) || r !== OKAY) begin n_fail++;
      $display("FAIL reset_status: got ok=%0d rdata=%h rresp=%b expected %h OKAY", ok, d, r, status_word(0, 1, 0, 0)); end
  endtask

  task automatic test_single();
    logic [1:0] r;
    time t;
    bit ok;
    int base = rx_b.size();
    axi_write(BASE, 32'h0000_0055, 4'h1, r, t, ok);
    n_cmp++; if (!ok || r !== OKAY) begin n_fail++; $display("FAIL single_bresp: got ok=%0d bresp=%b expected OKAY", ok, r); end
    wait_rx(base + 1, FRAME + 50);
    n_cmp++; if (rx_b.size() !== base + 1) begin n_fail++; $display("FAIL single_count: got %0d frames expected %0d", rx_b.size(), base + 1); end
    else begin
      n_cmp++; if (rx_b[base] !== 8'h55 || rx_f[base] !== 1'b1) begin n_fail++;
        $display("FAIL single_frame: got byte=%h framing=%0d expected 55 framing=1", rx_b[base], rx_f[base]); end
      n_cmp++; if (fall_t[base] - t !== 20) begin n_fail++;
        $display("FAIL single_latency: got %0t expected 20 after accept", fall_t[base] - t); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[18];
    bit used[256];
    logic [1:0] r;
    logic [31:0] d;
    time t;
    bit ok;
    int v;
    int base = rx_b.size();
    for (int i = 0; i < 18; i++) begin
      do v = $urandom_range(0, 255); while (used[v]);
      used[v] = 1;
      vals[i] = 8'(v);
    end
    for (int i = 0; i < 17; i++) begin
      axi_write(BASE, {$urandom, vals[i]} >> 0 & 32'hFFFF_FF00 | 32'(vals[i]), 4'h1, r, t, ok);
      n_cmp++; if (!ok || r !== OKAY) begin n_fail++; $display("FAIL b2b_resp[%0d]: got ok=%0d bresp=%b expected OKAY", i, ok, r); end
    end
    axi_write(BASE, 32'(vals[17]), 4'h1, r, t, ok);
    n_cmp++; if (!ok || r !== SLVERR) begin n_fail++; $display("FAIL b2b_full_resp: got ok=%0d bresp=%b expected SLVERR", ok, r); end
    axi_read(BASE + 4, d, r, ok);
    n_cmp++; if (!ok || d !== status_word(1, 0, 1, 16)) begin n_fail++;
      $display("FAIL b2b_status: got %h expected %h", d, status_word(1, 0, 1, 16)); end
    wait_rx(base + 17, 17 * (FRAME + 1) + 200);
    n_cmp++; if (rx_b.size() !== base + 17) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", rx_b.size(), base + 17); end
    else begin
      for (int i = 0; i < 17; i++) begin
        n_cmp++; if (rx_b[base + i] !== vals[i] || rx_f[base + i] !== 1'b1) begin n_fail++;
          $display("FAIL b2b_byte[%0d]: got %h framing=%0d expected %h", i, rx_b[base + i], rx_f[base + i], vals[i]); end
      end
      for (int i = 0; i < 16; i++) begin
        n_cmp++; if (fall_t[base + i + 1] - fall_t[base + i] !== (FRAME + 1) * 10) begin n_fail++;
          $display("FAIL b2b_gap[%0d]: got %0t expected %0d", i, fall_t[base + i + 1] - fall_t[base + i], (FRAME + 1) * 10); end
      end
    end
    repeat (FRAME + 20) @(posedge clk);
    n_cmp++; if (rx_b.size() !== base + 17) begin n_fail++; $display("FAIL b2b_dropped: got %0d frames expected %0d", rx_b.size(), base + 17); end
  endtask

  task automatic test_status_mid();
    logic [7:0] vals[4];
    logic [1:0] r;
    logic [31:0] d;
    time t;
    bit ok;
    int base = rx_b.size();
    for (int i = 0; i < 4; i++) begin
      vals[i] = 8'($urandom);
      axi_write(BASE, 32'(vals[i]), 4'h1, r, t, ok);
    end
    axi_read(BASE + 4, d, r, ok);
    n_cmp++; if (!ok || d !== status_word(0, 0, 1, 3) || r !== OKAY) begin n_fail++;
      $display("FAIL mid_status: got %h rresp=%b expected %h", d, r, status_word(0, 0, 1, 3)); end
    wait_rx(base + 4, 4 * (FRAME + 1) + 100);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx_b.size() <= base + i || rx_b[base + i] !== vals[i]) begin n_fail++;
        $display("FAIL mid_byte[%0d]: got %0d frames expected byte %h", i, rx_b.size() - base, vals[i]); end
    end
  endtask

  task automatic test_decode();
    logic [1:0] r;
    logic [31:0] d;
    time t;
    bit ok;
    int nf = n_falls;
    axi_write(BASE + 32'h10, 32'h41, 4'h1, r, t, ok);
    n_cmp++; if (!ok || r !== DECERR) begin n_fail++; $display("FAIL dec_wr_10: got bresp=%b expected DECERR", r); end
    axi_write(BASE + 32'h8, 32'h42, 4'h1, r, t, ok);
    n_cmp++; if (!ok || r !== DECERR) begin n_fail++; $display("FAIL dec_wr_08: got bresp=%b expected DECERR", r); end
    axi_write(BASE - 32'h4, 32'h43, 4'h1, r, t, ok);
    n_cmp++; if (!ok || r !== DECERR) begin n_fail++; $display("FAIL dec_wr_below: got bresp=%b expected DECERR", r); end
    axi_read(BASE + 32'h10, d, r, ok);
    n_cmp++; if (!ok || r !== DECERR || d !== 32'h0) begin n_fail++; $display("FAIL dec_rd_10: got rdata=%h rresp=%b expected 0 DECERR", d, r); end
    axi_write(BASE + 4, 32'h44, 4'h1, r, t, ok);
    n_cmp++; if (!ok || r !== OKAY) begin n_fail++; $display("FAIL status_write: got bresp=%b expected OKAY", r); end
    axi_write(BASE, 32'h45, 4'h2, r, t, ok);
    n_cmp++; if (!ok || r !== OKAY) begin n_fail++; $display("FAIL nostrb_write: got bresp=%b expected OKAY", r); end
    axi_read(BASE, d, r, ok);
    n_cmp++; if (!ok || r !== OKAY || d !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got rdata=%h rresp=%b expected 0 OKAY", d, r); end
    axi_read(BASE + 4, d, r, ok);
    n_cmp++; if (!ok || d !== status_word(0, 1, 0, 0)) begin n_fail++; $display("FAIL dec_status: got %h expected %h", d, status_word(0, 1, 0, 0)); end
    repeat (20) @(posedge clk);
    n_cmp++; if (n_falls !== nf) begin n_fail++; $display("FAIL dec_no_tx: got %0d starts expected %0d", n_falls, nf); end
  endtask

  task automatic test_bhold();
    logic [7:0] d1, d2;
    bit stable = 1, held = 1;
    int base = rx_b.size();
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    @(negedge clk);
    awaddr = BASE; wdata = 32'(d1); wstrb = 4'h1; awvalid = 1; wvalid = 1;
    #1;
    for (int n = 0; n < 50 && !awready; n++) begin @(negedge clk); #1; end
    @(posedge clk);
    #1;
    wdata = 32'(d2);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || bresp !== OKAY) stable = 0;
      if (awready !== 1'b0 || wready !== 1'b0) held = 0;
    end
    n_cmp++; if (!stable) begin n_fail++; $display("FAIL bhold_stable: got bvalid=%b bresp=%b expected held 1/OKAY", bvalid, bresp); end
    n_cmp++; if (!held) begin n_fail++; $display("FAIL bhold_ready: got awready/wready high expected low while bvalid"); end
    bready = 1;
    @(posedge clk);
    #1;
    bready = 0;
    n_cmp++; if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0) begin n_fail++;
      $display("FAIL bhold_next: got awready=%b wready=%b bvalid=%b expected 1 1 0", awready, wready, bvalid); end
    @(posedge clk);
    #1;
    awvalid = 0; wvalid = 0;
    n_cmp++; if (bvalid !== 1'b1 || bresp !== OKAY) begin n_fail++; $display("FAIL bhold_second_b: got bvalid=%b bresp=%b expected 1 OKAY", bvalid, bresp); end
    bready = 1;
    @(posedge clk);
    #1;
    bready = 0;
    wait_rx(base + 2, 2 * (FRAME + 1) + 100);
    n_cmp++; if (rx_b.size() !== base + 2 || rx_b[base] !== d1 || rx_b[base + 1] !== d2) begin n_fail++;
      $display("FAIL bhold_bytes: got %0d frames expected %h %h", rx_b.size() - base, d1, d2); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r;
    logic [31:0] d;
    time t;
    bit ok;
    int base = rx_b.size();
    int nf = n_falls;
    axi_write(BASE, 32'($urandom) & 32'hEF, 4'h1, r, t, ok);
    axi_write(BASE, 32'($urandom), 4'h1, r, t, ok);
    for (int n = 0; n < FRAME && n_falls == nf; n++) @(posedge clk);
    #(5 * BIT + BIT / 2);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd: got %b expected 1", txd); end
    rst = 0;
    axi_read(BASE + 4, d, r, ok);
    n_cmp++; if (!ok || d !== status_word(0, 1, 0, 0)) begin n_fail++; $display("FAIL rstmid_status: got %h expected %h", d, status_word(0, 1, 0, 0)); end
    repeat (2 * FRAME + 20) @(posedge clk);
    n_cmp++; if (n_falls !== nf + 1 || rx_b.size() !== base || txd !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_residual: got starts=%0d frames=%0d expected %0d %0d", n_falls - nf, rx_b.size() - base, 1, 0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_status_mid();
    test_decode();
    test_bhold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_uart_tx.md
# axil_uart_tx

AXI4-Lite slave peripheral that accepts bytes written by the core and transmits them serially as 8N1 UART frames on `txd`. Sits beside the LED slave on the core's AXI bus. Provides the transmit direction of the console link: it consumes writes issued by the core and drives the serial line out, while a status register lets firmware poll FIFO and line state. It buffers writes in a small FIFO so the core is not stalled for the duration of a frame.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, AXI data width; fixed at 32.
- `BASE_ADDR`, 32'h0000_0100, base of the 8-byte register window.
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); ≥ 2.
- `FIFO_DEPTH`, 16, TX FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `awaddr`  in  ADDR_WIDTH  write address.
- `awvalid` / `awready`  in / out  1  write-address handshake.
- `wdata`  in  DATA_WIDTH  write data.
- `wstrb`  in  DATA_WIDTH/8  byte strobes.
- `wvalid` / `wready`  in / out  1  write-data handshake.
- `bresp`  out  2  write response.
- `bvalid` / `bready`  out / in  1  write-response handshake.
- `araddr`  in  ADDR_WIDTH  read address.
- `arvalid` / `arready`  in / out  1  read-address handshake.
- `rdata`  out  DATA_WIDTH  read data.
- `rresp`  out  2  read response.
- `rvalid` / `rready`  out / in  1  read-data handshake.
- `txd`  out  1  serial output; idle high.

## Operation
- Registers, offsets from BASE_ADDR:
  - 0x0 TXDATA: write-only. A write pushes `wdata[7:0]` when `wstrb[0]`=1. Reads return 0.
  - 0x4 STATUS: read-only. Bit 0 = fifo_full, bit 1 = fifo_empty, bit 2 = tx_busy (FSM not IDLE), bits [15:8] = FIFO level. Other bits are 0. Writes are ignored and answered OKAY.
- Unmapped address (outside the window): BRESP/RRESP = DECERR (2'b11), RDATA = 0, no side effects.
- Write to TXDATA while the FIFO is full: the byte is dropped and BRESP = SLVERR (2'b10). The full test uses the FIFO state before any same-cycle pop.
- Write to TXDATA with `wstrb[0]`=0: nothing is pushed; response OKAY.
- TX FSM states:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START. `txd` = 1.
  - START: `txd` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, counted by a 3-bit bit index; then go to STOP.
  - STOP: `txd` = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter runs from 0 to CLKS_PER_BIT-1 and wraps; width is $clog2(CLKS_PER_BIT).

## Timing
- Reset values: `txd`=1; `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0; `bresp`, `rresp`, `rdata` = 0. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-frame aborts the frame: `txd` is high on the cycle after `rst` is sampled.
- Write channel: `awready` and `wready` pulse together for one cycle when `awvalid` && `wvalid` && !`bvalid`. A lone AW or W waits for its partner. The push happens on that accept edge. `bvalid` rises the next cycle and holds until `bready`. The next write can be accepted in the cycle after the B handshake.
- Read channel: `arready` pulses for one cycle when `arvalid` && !`rvalid`. `rvalid`, `rdata` and `rresp` are valid the next cycle and are held stable until `rready`. STATUS reflects state at the AR accept edge.
- Frame latency: a push into an empty FIFO while the FSM is IDLE makes `txd` fall 2 cycles after the write accept edge (push, then pop, then START).
- Frame length is 10×CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly 1 IDLE cycle.
- A simultaneous push and pop at a non-full level leaves the level unchanged.

## Structure
- Package `uart_pkg`: register offsets (TXDATA_OFS, STATUS_OFS), STATUS bit indices, AXI response constants (RESP_OKAY/SLVERR/DECERR), and the TX state enum `uart_tx_state_e`.
- Sub-module `sync_fifo`: parameters WIDTH and DEPTH, a single clock, and a synchronous active-high reset. It exposes push, pop, full, empty and level. The top level holds the AXI-Lite decode and the TX FSM.

## Test plan
- Reset, then write 0x55 to TXDATA -> `txd` low 2 cycles after accept; bits 1,0,1,0,1,0,1,0 LSB-first at CLKS_PER_BIT spacing; stop bit high; BRESP=OKAY.
- 17 writes issued without pause, each of distinct data (FIFO_DEPTH=16) -> one byte is popped early, so all 17 are accepted and the 18th write returns SLVERR. Serial output matches write order exactly with 1-cycle inter-frame gaps.
- Read STATUS after reset -> RDATA=0x0000_0002. Read mid-frame with 3 queued bytes -> bit 2=1, [15:8]=3.
- Write to BASE_ADDR+0x10 and read from it -> DECERR, RDATA=0, FIFO level unchanged.
- Hold `bready`=0 for 20 cycles -> `bvalid`/`bresp` stable; `awready`/`wready` stay low for a queued second write until the B handshake completes.
- Assert `rst` at bit 4 of a frame -> `txd`=1 on the next cycle, STATUS=0x2 afterwards, and no residual frame is sent.
